// File: rtl/lif_neuron_array.sv
// lif_neuron_array: array of N_CH independent leaky integrate-and-fire neurons
// that all advance on a shared prescaled update tick.
// Optional feature macro: LIF_SPIKE_COUNT_EN adds a saturating 8-bit spike
// counter per channel, read back through cnt_out and cleared by cnt_clr.
// Timing: there is no valid/ready handshake. tick is a one-clk pulse, and
// spike_out is a one-clk pulse in the cycle after the update edge.
// vmem_out and cnt_out are plain combinational reads of the state registers,
// selected by sel.
module lif_neuron_array #(
  parameter int          N_CH      = 4,
  parameter int          V_W       = 8,
  parameter int          REF_TICKS = 2,
  parameter int unsigned MAX_COUNT = 24'd10_000_000,
  localparam int         SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*V_W-1:0]   stim,
  input  logic [V_W-1:0]        threshold,
  input  logic [2:0]            leak_shift,
  input  logic [SEL_W-1:0]      sel,
  output logic                  tick,
  output logic [N_CH-1:0]       spike_out,
  output logic [V_W-1:0]        vmem_out,
  input  logic                  cnt_clr,
  output logic [7:0]            cnt_out
);

  localparam int CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  logic [CNT_W-1:0] r_pre;
  logic             r_tick;
  logic             w_wrap;

  logic [V_W-1:0]   r_v     [N_CH];
  logic [3:0]       r_ref   [N_CH];
  logic [N_CH-1:0]  r_spike;

  logic [V_W-1:0]   w_vleak [N_CH];
  logic [V_W:0]     w_sum   [N_CH];
  logic [V_W-1:0]   w_vn    [N_CH];
  logic [N_CH-1:0]  w_fire;
  logic [N_CH-1:0]  w_fire_now;

  assign w_wrap = (r_pre == CNT_W'(MAX_COUNT - 1));

  // Prescaler: count 0..MAX_COUNT-1 and register a pulse when the count wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= w_wrap ? '0 : r_pre + 1'b1;
      r_tick <= w_wrap;
    end
  end

  // Candidate next potential per channel: leak, add stimulus, saturate, compare.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_vleak[k]    = (leak_shift != 3'd0) ? (r_v[k] - (r_v[k] >> leak_shift)) : r_v[k];
      w_sum[k]      = {1'b0, w_vleak[k]} + {1'b0, stim[k*V_W +: V_W]};
      w_vn[k]       = w_sum[k][V_W] ? {V_W{1'b1}} : w_sum[k][V_W-1:0];
      w_fire[k]     = (w_vn[k] >= threshold);
      w_fire_now[k] = r_tick && (r_ref[k] == 4'd0) && w_fire[k];
    end
  end

  // Neuron state: update on tick edges only; spike pulses clear on every other edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        r_v[k]   <= '0;
        r_ref[k] <= '0;
      end
      r_spike <= '0;
    end else begin
      r_spike <= '0;
      if (r_tick) begin
        for (int k = 0; k < N_CH; k++) begin
          if (r_ref[k] != 4'd0) begin
            // Refractory: the stimulus is ignored and the potential is pinned at 0.
            r_ref[k] <= r_ref[k] - 4'd1;
            r_v[k]   <= '0;
          end else if (w_fire[k]) begin
            r_spike[k] <= 1'b1;
            r_v[k]     <= '0;
            r_ref[k]   <= 4'(REF_TICKS);
          end else begin
            r_v[k] <= w_vn[k];
          end
        end
      end
    end
  end

  assign tick      = r_tick;
  assign spike_out = r_spike;

  // Readback mux for the membrane potential; an out-of-range select reads 0.
  always_comb begin
    vmem_out = '0;
    if (int'(sel) < N_CH) vmem_out = r_v[sel];
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] r_cnt [N_CH];

  // Spike counters: saturate at 255; a clear wins over a coincident spike.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int k = 0; k < N_CH; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_fire_now[k] && (r_cnt[k] != 8'hFF)) r_cnt[k] <= r_cnt[k] + 8'd1;
      end
    end
  end

  // Readback mux for the spike count; an out-of-range select reads 0.
  always_comb begin
    cnt_out = '0;
    if (int'(sel) < N_CH) cnt_out = r_cnt[sel];
  end
`else
  logic w_unused_cnt;

  assign cnt_out      = '0;
  assign w_unused_cnt = cnt_clr ^ (|w_fire_now);
`endif

endmodule

// File: doc/lif_neuron_array.md
LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 Parameter N_CH, default 4: number of independent neuron channels (1..16).
REQ-002 Parameter V_W, default 8: membrane potential and stimulus width in bits (4..16).
REQ-003 Parameter REF_TICKS, default 2: refractory length in ticks after a spike (0..15).
REQ-004 Parameter MAX_COUNT, default 24'd10_000_000: clk cycles per neuron update tick (>=1).
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stim  in  N_CH*V_W  per-channel unsigned input current; channel k is bits [k*V_W +: V_W].
REQ-008 threshold  in  V_W  shared unsigned firing threshold.
REQ-009 leak_shift  in  3  leak divisor exponent; 0 disables leak.
REQ-010 sel  in  clog2(N_CH) (min 1)  channel select for the readback outputs.
REQ-011 tick  out  1  one-clk pulse marking a neuron update.
REQ-012 spike_out  out  N_CH  per-channel spike pulse, one clk wide.
REQ-013 vmem_out  out  V_W  membrane potential of channel sel (combinational mux of the registers).
REQ-014 cnt_clr  in  1  clears spike counters (feature of REQ-030).
REQ-015 cnt_out  out  8  spike count of channel sel (feature of REQ-030).

Function
REQ-016 A prescaler counts 0..MAX_COUNT-1 and wraps; tick is registered and is high for exactly one clk each time the count wraps to 0; MAX_COUNT=1 makes tick permanently high.
REQ-017 On every clk edge where tick=1, each channel updates; on other edges V, refractory counter and spike_out hold, except that spike_out clears to 0.
REQ-018 Refractory state (counter r>0): r decrements by 1, V forced to 0, stim ignored, no spike.
REQ-019 Active state (r=0): Vn = V - (V >> leak_shift) + stim when leak_shift!=0, else Vn = V + stim; the sum is computed at V_W+1 bits and saturates at 2^V_W-1.
REQ-020 Active state, Vn >= threshold: spike_out[k]=1 for the next clk, V=0, r=REF_TICKS; otherwise V=Vn, spike_out[k]=0.
REQ-021 threshold=0 makes every active-state tick fire; REF_TICKS=0 allows firing on consecutive ticks.
REQ-022 Channels are fully independent; simultaneous spikes on several channels are all reported in the same spike_out cycle.
REQ-023 stim, threshold and leak_shift are sampled only on tick edges; changes between ticks have no effect until the next tick.
REQ-024 sel >= N_CH drives vmem_out=0 and cnt_out=0.

Reset
REQ-025 rst=1 on a clk edge sets every V, r, prescaler count, tick and spike_out to 0; it takes priority over a coincident tick.
REQ-026 Reset mid-refractory or mid-integration discards that state; the first tick after release is at MAX_COUNT clks after rst falls.
REQ-027 Spike counters are cleared by rst.

Configuration
REQ-028 Macro LIF_SPIKE_COUNT_EN selects the spike-counter feature.
REQ-029 Without LIF_SPIKE_COUNT_EN: no counter registers exist, cnt_out is tied to 0 and cnt_clr is ignored.
REQ-030 With LIF_SPIKE_COUNT_EN: each channel has an 8-bit counter incremented on each of its spikes, saturating at 255; cnt_clr=1 zeroes all counters and wins over a coincident spike.

Verification (N_CH=4, V_W=8, REF_TICKS=2, MAX_COUNT=1 unless stated)
REQ-031 Integrate/fire: leak_shift=0, threshold=10, stim ch0=3 -> V ch0 3,6,9, spike after 4th tick, V 0,0 (refractory), 3,... and other channels stay 0.
REQ-032 Saturation: threshold=255, stim ch1=200 -> V 200, then saturates to 255, spike on 2nd tick, V=0.
REQ-033 Leak: leak_shift=1, threshold=200, stim ch2=4 -> V 4,6,7,8,8,8 steady, no spike.
REQ-034 Reset mid-operation: rst asserted for 1 clk while V ch0=9 and ch1 refractory -> all V=0, r=0, spike_out=0; next tick integrates from 0.
REQ-035 Prescaler: MAX_COUNT=4 -> tick high one clk in every 4; V changes only on those edges; stim changed between ticks is ignored.
REQ-036 With LIF_SPIKE_COUNT_EN, threshold=0, REF_TICKS=0 -> cnt_out reaches 255 after 255 ticks and holds; cnt_clr pulse -> 0.
